// File: rtl/fp_sched_pkg.sv
// fp_sched_pkg: shared types and rotated-priority grant for schedulers of shared FP units
package fp_sched_pkg;
    localparam int FP_WIDTH = 32;
    localparam int MAX_REQ = 8;
    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } tag_t;
    // One-hot grant to the first eligible lane after ptr, scanning n lanes circularly
    function automatic logic [MAX_REQ-1:0] rr_grant(input logic [MAX_REQ-1:0] elig,
                                                    input logic [2:0] ptr, input int n);
        logic [MAX_REQ-1:0] g;
        logic [2:0] idx;
        g = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = 3'((int'(ptr) + k) % n);
            if (k <= n && g == '0 && elig[idx]) g[idx] = 1'b1;
        end
        return g;
    endfunction
endpackage

// File: rtl/fp_add_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter with encoded winner index
module rr_arbiter
    import fp_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);
    assign grant = NUM_REQ'(rr_grant(MAX_REQ'(eligible), 3'(rr_ptr), NUM_REQ));
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) grant_idx = grant[i] ? IW'(i) : grant_idx;
    end
endmodule

// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: round-robin sharing of one registered FP adder among NUM_REQ requesters.
// Define FP_ADD_SCHED_PERF_EN to add issue/stall performance counters.
module fp_add_scheduler
    import fp_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDER_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [FP_WIDTH*NUM_REQ-1:0] req_a,
    input  logic [FP_WIDTH*NUM_REQ-1:0] req_b,
    output logic [FP_WIDTH-1:0]         add_a,
    output logic [FP_WIDTH-1:0]         add_b,
    input  logic [FP_WIDTH-1:0]         add_result,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [FP_WIDTH-1:0]         resp_result
`ifdef FP_ADD_SCHED_PERF_EN
    ,
    output logic [31:0]                 perf_issue_cnt,
    output logic [31:0]                 perf_stall_cnt
`endif
);
    localparam int IW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]  busy, elig, grant;
    logic [IW-1:0]       rr_ptr, gidx;
    logic [FP_WIDTH-1:0] sel_a, sel_b;
    tag_t                tags [ADDER_LAT];
    assign elig        = req_valid & ~busy;
    assign req_ready   = grant;
    assign resp_result = add_result;
    assign sel_a       = req_a[int'(gidx)*FP_WIDTH +: FP_WIDTH];
    assign sel_b       = req_b[int'(gidx)*FP_WIDTH +: FP_WIDTH];
    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .eligible (elig),
        .rr_ptr   (rr_ptr),
        .grant    (grant),
        .grant_idx(gidx)
    );
    // The tag rides alongside the adder; resp_valid adds the final register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            add_a      <= '0;
            add_b      <= '0;
            busy       <= '0;
            resp_valid <= '0;
            rr_ptr     <= IW'(NUM_REQ - 1);
            for (int s = 0; s < ADDER_LAT; s++) tags[s] <= '0;
        end else begin
            if (|grant) begin
                add_a  <= sel_a;
                add_b  <= sel_b;
                rr_ptr <= gidx;
            end
            busy    <= (busy & ~resp_valid) | grant;
            tags[0] <= '{valid: |grant, id: 3'(gidx)};
            for (int s = 1; s < ADDER_LAT; s++) tags[s] <= tags[s-1];
            for (int i = 0; i < NUM_REQ; i++)
                resp_valid[i] <= tags[ADDER_LAT-1].valid && tags[ADDER_LAT-1].id == 3'(i);
        end
    end
`ifdef FP_ADD_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_issue_cnt <= perf_issue_cnt + 32'(|grant);
            perf_stall_cnt <= perf_stall_cnt + 32'(|(req_valid & ~grant));
        end
    end
`endif
endmodule

// File: tb/tb_fp_add_scheduler.sv
// tb_fp_add_scheduler: directed self-checking bench with a registered lookup-table adder model
module tb_fp_add_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [31:0] add_a, add_b;
    logic [31:0] add_result = '0;
    logic [1:0]  resp_valid;
    logic [31:0] resp_result;
`ifdef FP_ADD_SCHED_PERF_EN
    logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif
    int cmp = 0;
    int bad = 0;

    fp_add_scheduler #(.NUM_REQ(2), .ADDER_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .resp_valid (resp_valid),
        .resp_result(resp_result)
`ifdef FP_ADD_SCHED_PERF_EN
        ,
        .perf_issue_cnt(perf_issue_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F000000 && b == 32'h3F000000) return 32'h3F800000;
        if (a == 32'hBF400000 && b == 32'hBF400000) return 32'hBFC00000;
        if (a == 32'h3F000000 && b == 32'hBEE00000) return 32'h3D800000;
        if (a == 32'hBEE00000 && b == 32'h3F000000) return 32'h3D800000;
        return 32'hDEADBEEF;
    endfunction

    always @(posedge clk) add_result <= fadd(add_a, add_b);

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        cycle();
        cycle();
        #1;
        cmp++; if (add_a !== 32'h0) begin bad++; $display("FAIL reset_add_a: got %h want 00000000", add_a); end
        cmp++; if (add_b !== 32'h0) begin bad++; $display("FAIL reset_add_b: got %h want 00000000", add_b); end
        cmp++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid); end
        req_valid = 2'b11;
        #1;
        cmp++; if (req_ready !== 2'b01) begin bad++; $display("FAIL reset_first_winner: got %b want 01", req_ready); end
        req_valid = 2'b00;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_single();
        req_a[31:0] = 32'h3F000000;
        req_b[31:0] = 32'h3F000000;
        req_valid = 2'b01;
        #1;
        cmp++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_ready: got %b want 01", req_ready); end
        cycle();
        req_valid = 2'b00;
        #1;
        cmp++; if (add_a !== 32'h3F000000) begin bad++; $display("FAIL single_add_a: got %h want 3f000000", add_a); end
        cmp++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL single_early_resp: got %b want 00", resp_valid); end
        cycle();
        cmp++; if (resp_valid !== 2'b01) begin bad++; $display("FAIL single_resp_valid: got %b want 01", resp_valid); end
        cmp++; if (resp_result !== 32'h3F800000) begin bad++; $display("FAIL single_result: got %h want 3f800000", resp_result); end
        cycle();
        cmp++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL single_resp_drop: got %b want 00", resp_valid); end
        cycle();
    endtask

    task automatic test_negative();
        req_a[63:32] = 32'hBF400000;
        req_b[63:32] = 32'hBF400000;
        req_valid = 2'b10;
        #1;
        cmp++; if (req_ready !== 2'b10) begin bad++; $display("FAIL neg_ready: got %b want 10", req_ready); end
        cycle();
        req_valid = 2'b00;
        cycle();
        cmp++; if (resp_valid !== 2'b10) begin bad++; $display("FAIL neg_resp_valid: got %b want 10", resp_valid); end
        cmp++; if (resp_result !== 32'hBFC00000) begin bad++; $display("FAIL neg_result: got %h want bfc00000", resp_result); end
        cycle();
        cycle();
    endtask

    // Single requester held valid: grant, busy, response bubble, grant again
    task automatic test_outstanding_limit();
        req_a[31:0] = 32'h3F000000;
        req_b[31:0] = 32'h3F000000;
        req_valid = 2'b01;
        for (int k = 0; k < 9; k++) begin
            #1;
            cmp++;
            if (req_ready !== ((k % 3 == 0) ? 2'b01 : 2'b00)) begin
                bad++; $display("FAIL limit_ready k=%0d: got %b want %b", k, req_ready, (k % 3 == 0) ? 2'b01 : 2'b00);
            end
            cmp++;
            if (resp_valid !== ((k % 3 == 2) ? 2'b01 : 2'b00)) begin
                bad++; $display("FAIL limit_resp k=%0d: got %b want %b", k, resp_valid, (k % 3 == 2) ? 2'b01 : 2'b00);
            end
            cycle();
        end
        req_valid = 2'b00;
        repeat (4) cycle();
    endtask

    task automatic test_contention();
        logic [1:0] rdy_tab [3];
        logic [1:0] resp_exp;
        rdy_tab = '{2'b01, 2'b10, 2'b00};
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req_a = {32'hBEE00000, 32'h3F000000};
        req_b = {32'h3F000000, 32'hBEE00000};
        req_valid = 2'b11;
        for (int k = 0; k < 9; k++) begin
            resp_exp = (k % 3 == 2) ? 2'b01 : ((k % 3 == 0 && k > 0) ? 2'b10 : 2'b00);
            #1;
            cmp++;
            if (req_ready !== rdy_tab[k % 3]) begin
                bad++; $display("FAIL contention_ready k=%0d: got %b want %b", k, req_ready, rdy_tab[k % 3]);
            end
            cmp++;
            if (resp_valid !== resp_exp) begin
                bad++; $display("FAIL contention_resp k=%0d: got %b want %b", k, resp_valid, resp_exp);
            end
            if (resp_exp != 2'b00) begin
                cmp++;
                if (resp_result !== 32'h3D800000) begin
                    bad++; $display("FAIL contention_result k=%0d: got %h want 3d800000", k, resp_result);
                end
            end
            cycle();
        end
        req_valid = 2'b00;
        repeat (4) cycle();
    endtask

    task automatic test_reset_midflight();
        int seen;
        seen = 0;
        req_a[31:0] = 32'h3F000000;
        req_b[31:0] = 32'h3F000000;
        req_valid = 2'b01;
        #1;
        cmp++; if (req_ready !== 2'b01) begin bad++; $display("FAIL midflight_grant: got %b want 01", req_ready); end
        cycle();
        req_valid = 2'b00;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (resp_valid !== 2'b00) seen++;
            cycle();
        end
        cmp++; if (seen !== 0) begin bad++; $display("FAIL midflight_resp: got %0d resp cycles want 0", seen); end
        req_valid = 2'b11;
        #1;
        cmp++; if (req_ready !== 2'b01) begin bad++; $display("FAIL midflight_after_rst: got %b want 01", req_ready); end
        req_valid = 2'b00;
        repeat (4) cycle();
    endtask

`ifdef FP_ADD_SCHED_PERF_EN
    task automatic test_perf();
        logic [1:0] pat [8];
        pat = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            req_valid = pat[k];
            cycle();
        end
        req_valid = 2'b00;
        #1;
        cmp++; if (perf_issue_cnt !== 32'd4) begin bad++; $display("FAIL perf_issue: got %0d want 4", perf_issue_cnt); end
        cmp++; if (perf_stall_cnt !== 32'd3) begin bad++; $display("FAIL perf_stall: got %0d want 3", perf_stall_cnt); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cmp++; if (perf_issue_cnt !== 32'd0) begin bad++; $display("FAIL perf_issue_rst: got %0d want 0", perf_issue_cnt); end
        cmp++; if (perf_stall_cnt !== 32'd0) begin bad++; $display("FAIL perf_stall_rst: got %0d want 0", perf_stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_negative();
        test_outstanding_limit();
        test_contention();
        test_reset_midflight();
`ifdef FP_ADD_SCHED_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
